// File: rtl/fw_ram_ctrl_pkg.sv
// Shared definitions for the firmware RAM controller: FSM states, RAM size
// and the default word written by the clear engine.
package fw_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'd0,
        CTRL_CPU_ACK = 2'd1,
        CTRL_CLEAR   = 2'd2,
        CTRL_FLUSH   = 2'd3
    } ctrl_state_t;

    localparam int unsigned FW_RAM_WORDS   = 1024;
    localparam logic [31:0] FW_CLEAR_VALUE = 32'h0;

endpackage

// File: rtl/fw_ram_ctrl.sv
// Firmware RAM controller: arbitrates the RAM between single-word CPU accesses
// and a clear engine that overwrites every word with CLEAR_VALUE. A pending
// clear wins over the CPU in IDLE; CPU requests are held off (never dropped)
// until the clear finishes. Raising fw_app_mode aborts a running clear.
module fw_ram_ctrl
    import fw_ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter logic [31:0] CLEAR_VALUE    = FW_CLEAR_VALUE,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fw_app_mode,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  clear_error,
    input  logic                  cpu_cs,
    input  logic [3:0]            cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [31:0]           cpu_write_data,
    output logic [31:0]           cpu_read_data,
    output logic                  cpu_ready,
    output logic                  ram_cs,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_write_data,
    input  logic [31:0]           ram_read_data,
    input  logic                  ram_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ctrl_state_t           state;
    ctrl_state_t           state_next;
    logic [ADDR_WIDTH-1:0] counter;
    logic [ADDR_WIDTH-1:0] counter_next;
    logic                  clear_pending;
    logic                  pending_next;
    logic                  error_next;
    logic                  done_next;
    logic                  start_ok;

    // A clear request is honoured only outside app mode and when no clear is
    // already running (no restart from CLEAR/FLUSH).
    assign start_ok   = clear_start & ~fw_app_mode &
                        (state != CTRL_CLEAR) & (state != CTRL_FLUSH);
    assign clear_busy = clear_pending | (state == CTRL_CLEAR) | (state == CTRL_FLUSH);

    // Next-state, clear bookkeeping and RAM/CPU strobes.
    always_comb begin
        state_next     = state;
        counter_next   = counter;
        pending_next   = clear_pending;
        error_next     = clear_error;
        done_next      = 1'b0;
        ram_cs         = 1'b0;
        ram_we         = '0;
        ram_address    = '0;
        ram_write_data = '0;
        cpu_ready      = 1'b0;
        cpu_read_data  = ram_read_data;

        if (start_ok) begin
            pending_next = 1'b1;
            error_next   = 1'b0;
        end

        case (state)
            CTRL_IDLE: begin
                if (clear_pending && !fw_app_mode) begin
                    state_next   = CTRL_CLEAR;
                    counter_next = '0;
                end else if (cpu_cs) begin
                    ram_cs         = 1'b1;
                    ram_we         = cpu_we;
                    ram_address    = cpu_address;
                    ram_write_data = cpu_write_data;
                    state_next     = CTRL_CPU_ACK;
                end
            end
            CTRL_CPU_ACK: begin
                cpu_ready  = ram_ready;
                state_next = CTRL_IDLE;
            end
            CTRL_CLEAR: begin
                if (fw_app_mode) begin
                    state_next   = CTRL_IDLE;
                    error_next   = 1'b1;
                    pending_next = 1'b0;
                end else begin
                    ram_cs         = 1'b1;
                    ram_we         = '1;
                    ram_address    = counter;
                    ram_write_data = CLEAR_VALUE;
                    if (counter == LAST_ADDR) begin
                        state_next = CTRL_FLUSH;
                    end else begin
                        counter_next = counter + 1'b1;
                    end
                end
            end
            CTRL_FLUSH: begin
                done_next    = 1'b1;
                pending_next = 1'b0;
                state_next   = CTRL_IDLE;
            end
            default: state_next = CTRL_IDLE;
        endcase

        // Reset is synchronous, so the state register still shows the old
        // operation during the reset cycle; suppress its strobes here.
        if (reset) begin
            ram_cs    = 1'b0;
            ram_we    = '0;
            cpu_ready = 1'b0;
        end
    end

    // State, address counter and clear status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CTRL_IDLE;
            counter       <= '0;
            clear_pending <= CLEAR_ON_RESET;
            clear_error   <= 1'b0;
            clear_done    <= 1'b0;
        end else begin
            state         <= state_next;
            counter       <= counter_next;
            clear_pending <= pending_next;
            clear_error   <= error_next;
            clear_done    <= done_next;
        end
    end

endmodule
